// File: rtl/rect_fill_engine.sv
// Rectangle fill stage: turns one latched fill command into a row-major stream of
// 1-bit framebuffer writes over a req/gnt port, with busy/done/error status.
module rect_fill_engine #(
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 200,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_fill,
    input  logic          fill_value,
    input  logic [XW-1:0] X1,
    input  logic [YW-1:0] Y1,
    input  logic [XW-1:0] X2,
    input  logic [YW-1:0] Y2,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_data,
    input  logic          mem_gnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [XW-1:0]   x_r;
    logic [YW-1:0]   y_r;
    logic [XW-1:0]   x1_r;
    logic [XW-1:0]   x2_r;
    logic [YW-1:0]   y2_r;
    logic [AW-1:0]   row_base_r;

    logic            illegal_s;
    logic [AW-1:0]   start_row_base_s;
    logic [AW-1:0]   next_row_base_s;

    // Row base is a constant-coefficient product, used only once per command.
    function automatic logic [AW-1:0] row_base_f(input logic [YW-1:0] y);
        return AW'(y) * AW'(SCREEN_W);
    endfunction

    // Command legality and row-base arithmetic for acceptance and row stepping.
    always_comb begin
        illegal_s        = (X1 > X2) || (Y1 > Y2) ||
                           (int'(X2) >= SCREEN_W) || (int'(Y2) >= SCREEN_H);
        start_row_base_s = row_base_f(Y1);
        next_row_base_s  = row_base_r + AW'(SCREEN_W);
    end

    // Command FSM with registered status and memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= 1'b0;
            x_r        <= '0;
            y_r        <= '0;
            x1_r       <= '0;
            x2_r       <= '0;
            y2_r       <= '0;
            row_base_r <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_fill) begin
                        x1_r     <= X1;
                        x2_r     <= X2;
                        y2_r     <= Y2;
                        mem_data <= fill_value;
                        if (illegal_s) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            error      <= 1'b0;
                            state_r    <= ST_RUN;
                            busy       <= 1'b1;
                            mem_req    <= 1'b1;
                            x_r        <= X1;
                            y_r        <= Y1;
                            row_base_r <= start_row_base_s;
                            mem_addr   <= start_row_base_s + AW'(X1);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Everything holds while the arbiter withholds the grant.
                    if (mem_gnt) begin
                        if (x_r != x2_r) begin
                            x_r      <= x_r + 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                        end else if (y_r != y2_r) begin
                            x_r        <= x1_r;
                            y_r        <= y_r + 1'b1;
                            row_base_r <= next_row_base_s;
                            mem_addr   <= next_row_base_s + AW'(x1_r);
                        end else begin
                            state_r <= ST_IDLE;
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: reset state, legal fills under continuous and
// stalled grants, rejected commands, the screen corner, start-while-busy and mid-fill reset.
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_fill = 1'b0;
    logic        fill_value = 1'b0;
    logic [8:0]  X1 = 9'd0;
    logic [7:0]  Y1 = 8'd0;
    logic [8:0]  X2 = 9'd0;
    logic [7:0]  Y2 = 8'd0;
    logic        busy, done, error, mem_req, mem_data;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;

    int checks = 0;
    int failures = 0;

    rect_fill_engine dut (
        .clk(clk), .reset(reset), .start_fill(start_fill), .fill_value(fill_value),
        .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2),
        .busy(busy), .done(done), .error(error),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: grant always high; mode 1: grant pattern 1,0,0,1,0,0,...
    // poke: pulse start_fill with different inputs while the fill is running.
    task automatic run_fill(input logic [8:0] x1, input logic [8:0] x2,
                            input logic [7:0] y1, input logic [7:0] y2,
                            input logic val, input int mode, input bit poke);
        int          exp_addr[$];
        int          k;
        bit          held;
        bit          fin;
        logic [15:0] held_addr;
        for (int y = int'(y1); y <= int'(y2); y++)
            for (int x = int'(x1); x <= int'(x2); x++)
                exp_addr.push_back(y * 320 + x);
        X1 = x1; X2 = x2; Y1 = y1; Y2 = y2; fill_value = val; start_fill = 1'b1;
        @(posedge clk); #1;
        start_fill = 1'b0;
        check_eq("accept_error_clear", 32'(error), 32'd0);
        k = 0; held = 1'b0; fin = 1'b0; held_addr = 16'd0;
        for (int c = 0; c < 400 && !fin; c++) begin
            mem_gnt = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (poke) begin
                start_fill = (c == 1);
                if (c == 1) begin
                    X1 = 9'd100; Y1 = 8'd100; X2 = 9'd100; Y2 = 8'd100; fill_value = ~val;
                end
            end
            if (k == exp_addr.size()) begin
                check_eq("end_done", 32'(done), 32'd1);
                check_eq("end_busy", 32'(busy), 32'd0);
                check_eq("end_req", 32'(mem_req), 32'd0);
                fin = 1'b1;
            end else begin
                check_eq("run_busy", 32'(busy), 32'd1);
                check_eq("run_req", 32'(mem_req), 32'd1);
                check_eq("run_done", 32'(done), 32'd0);
                check_eq("run_data", 32'(mem_data), 32'(val));
                if (held) check_eq("hold_addr", 32'(mem_addr), 32'(held_addr));
                if (mem_gnt) begin
                    check_eq("write_addr", 32'(mem_addr), 32'(exp_addr[k]));
                    k++;
                end
                held = !mem_gnt;
                held_addr = mem_addr;
                @(posedge clk); #1;
            end
        end
        if (!fin) check_eq("fill_timeout", 32'd0, 32'd1);
        mem_gnt = 1'b0; start_fill = 1'b0;
        @(posedge clk); #1;
        check_eq("done_pulse_len", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_reject(input logic [8:0] x1, input logic [8:0] x2,
                              input logic [7:0] y1, input logic [7:0] y2);
        X1 = x1; X2 = x2; Y1 = y1; Y2 = y2; fill_value = 1'b1; start_fill = 1'b1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        start_fill = 1'b0;
        check_eq("rej_done", 32'(done), 32'd1);
        check_eq("rej_error", 32'(error), 32'd1);
        check_eq("rej_busy", 32'(busy), 32'd0);
        check_eq("rej_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        check_eq("rej_done_clr", 32'(done), 32'd0);
        check_eq("rej_error_sticky", 32'(error), 32'd1);
        check_eq("rej_req_after", 32'(mem_req), 32'd0);
        mem_gnt = 1'b0;
    endtask

    initial begin
        int done_seen;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_data", 32'(mem_data), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_fill(9'd5, 9'd5, 8'd7, 8'd7, 1'b1, 0, 1'b0);
        run_fill(9'd0, 9'd2, 8'd0, 8'd1, 1'b1, 0, 1'b0);
        run_fill(9'd0, 9'd2, 8'd0, 8'd1, 1'b1, 1, 1'b0);
        run_reject(9'd10, 9'd9, 8'd0, 8'd0);
        run_reject(9'd0, 9'd320, 8'd0, 8'd0);
        run_reject(9'd0, 9'd0, 8'd0, 8'd200);
        run_fill(9'd319, 9'd319, 8'd199, 8'd199, 1'b1, 0, 1'b0);
        run_fill(9'd0, 9'd2, 8'd0, 8'd1, 1'b0, 0, 1'b1);

        // Reset after three grants of a 6-pixel fill.
        X1 = 9'd0; X2 = 9'd2; Y1 = 8'd0; Y2 = 8'd1; fill_value = 1'b1; start_fill = 1'b1;
        @(posedge clk); #1;
        start_fill = 1'b0;
        mem_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_addr", 32'(mem_addr), 32'd320);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || mem_req) done_seen++;
        end
        check_eq("post_rst_quiet", 32'(done_seen), 32'd0);
        mem_gnt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
